prog_loader: RTL and testbench

Synthesizable program loader and run controller for the RISC-V core. It accepts instruction words over a valid/ready stream and writes them into instruction memory from a configurable base address. It appends a terminator word and holds the core in reset until loading completes. It then releases the core for a cycle budget derived from the program length, and finally re-asserts core reset and reports completion. It sits between the host/test stream source and the core's `inst_mem` write port and `rst` input.

---
 rtl/prog_loader_if.sv | 24 ++
 rtl/prog_loader.sv | 115 +++++++++++
 tb/tb_prog_loader.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Stream-in / memory-write-out bundle for the program loader.
// The slave view belongs to the loader. The master view belongs to the host and memory side.
interface prog_loader_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
);
   logic              s_valid;
   logic              s_ready;
   logic [XLEN-1:0]   s_data;
   logic              s_last;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;

   modport master (
      output s_valid, s_data, s_last,
      input  s_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  s_valid, s_data, s_last,
      output s_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader and run controller.
// It streams instruction words into inst_mem from BASE_ADDR and appends a terminator.
// It then releases the core from reset for a budget derived from the program length.
module prog_loader #(
   parameter int                 XLEN         = 32,
   parameter int                 ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]  BASE_ADDR    = 'h4,
   parameter int unsigned        DEPTH        = 1024,
   parameter int unsigned        CYC_PER_WORD = 1,
   parameter int unsigned        TAIL_CYCLES  = 2,
   parameter logic [XLEN-1:0]    TERM_WORD    = '0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   prog_loader_if.slave                bus,
   output logic                        core_rst,
   output logic                        busy,
   output logic                        done,
   output logic                        err,
   output logic [$clog2(DEPTH+1)-1:0]  word_count
);
   localparam int WC_W = $clog2(DEPTH + 1);
   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(XLEN / 8);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_LOAD = 3'd1;
   localparam logic [2:0] S_TERM = 3'd2;
   localparam logic [2:0] S_RUN  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   logic [2:0]        state;
   logic [ADDR_W-1:0] ptr;
   logic [31:0]       budget;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [XLEN-1:0]   wdata_q;
   logic [WC_W-1:0]   wc_q;
   logic              err_q;
   logic              handshake;
   logic [63:0]       budget_full;
   logic [31:0]       budget_init;

   assign handshake     = bus.s_valid && (state == S_LOAD);
   assign bus.s_ready   = (state == S_LOAD);
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign core_rst      = (state != S_RUN);
   assign busy          = (state == S_LOAD) || (state == S_TERM) || (state == S_RUN);
   assign done          = (state == S_DONE);
   assign err           = err_q;
   assign word_count    = wc_q;

   // Run budget: words * cycles-per-word + tail, saturated to 32 bits
   always_comb begin
      budget_full = 64'(wc_q) * 64'(CYC_PER_WORD) + 64'(TAIL_CYCLES);
      budget_init = (budget_full > 64'h0000_0000_FFFF_FFFF) ? '1 : budget_full[31:0];
   end

   // Sequencer: load stream, write terminator, run the core, report completion
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_IDLE;
         ptr     <= '0;
         budget  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         wc_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         we_q <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state <= S_LOAD;
                  wc_q  <= '0;
                  err_q <= 1'b0;
                  ptr   <= BASE_ADDR;
               end
            end
            S_LOAD: begin
               if (handshake) begin
                  we_q    <= 1'b1;
                  addr_q  <= ptr;
                  wdata_q <= bus.s_data;
                  ptr     <= ptr + STEP;
                  wc_q    <= wc_q + 1'b1;
                  // s_last takes priority over the overflow condition on the same word
                  if (bus.s_last) begin
                     state <= S_TERM;
                  end else if (wc_q == WC_W'(DEPTH - 1)) begin
                     err_q <= 1'b1;
                     state <= S_DONE;
                  end
               end
            end
            S_TERM: begin
               we_q    <= 1'b1;
               addr_q  <= ptr;
               wdata_q <= TERM_WORD;
               budget  <= budget_init;
               state   <= S_RUN;
            end
            S_RUN: begin
               budget <= budget - 32'd1;
               // A zero budget still gets one run cycle and cannot wrap around
               if (budget <= 32'd1) state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader.
// Two instances are used: default DEPTH, and DEPTH=4 for the overflow cases.
module tb_prog_loader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   logic start_a, start_b;
   logic cr_a, busy_a, done_a, err_a;
   logic cr_b, busy_b, done_b, err_b;
   logic [10:0] wc_a;
   logic [2:0]  wc_b;

   prog_loader_if ifa ();
   prog_loader_if ifb ();

   prog_loader dut_a (
      .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
      .core_rst(cr_a), .busy(busy_a), .done(done_a), .err(err_a), .word_count(wc_a)
   );

   prog_loader #(.DEPTH(4)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
      .core_rst(cr_b), .busy(busy_b), .done(done_b), .err(err_b), .word_count(wc_b)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Observation mux: the active instance is chosen by sel
   int          sel = 0;
   logic        m_we, m_ready, m_cr, m_busy, m_done, m_err;
   logic [31:0] m_addr, m_wdata;
   int          m_wc;
   always_comb begin
      if (sel == 0) begin
         m_we = ifa.mem_we; m_ready = ifa.s_ready; m_cr = cr_a; m_busy = busy_a;
         m_done = done_a; m_err = err_a; m_addr = ifa.mem_addr; m_wdata = ifa.mem_wdata;
         m_wc = int'(wc_a);
      end else begin
         m_we = ifb.mem_we; m_ready = ifb.s_ready; m_cr = cr_b; m_busy = busy_b;
         m_done = done_b; m_err = err_b; m_addr = ifb.mem_addr; m_wdata = ifb.mem_wdata;
         m_wc = int'(wc_b);
      end
   end

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t wr_q[$];
   int  run_cnt = 0;
   int  cyc     = 0;

   // Monitor: log memory writes and count core-released cycles
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst && m_we) wr_q.push_back('{m_addr, m_wdata, cyc});
      if (rst && !m_cr) run_cnt = run_cnt + 1;
   end

   logic [31:0] words[16];
   int          pat[3];

   task automatic chk(input string nm, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_in(input bit v, input logic [31:0] d, input bit l);
      if (sel == 0) begin
         ifa.s_valid = v; ifa.s_data = d; ifa.s_last = l;
      end else begin
         ifb.s_valid = v; ifb.s_data = d; ifb.s_last = l;
      end
   endtask

   task automatic set_start(input bit v);
      if (sel == 0) start_a = v;
      else          start_b = v;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_s_ready"}, m_ready, 0);
      chk({tag, "_mem_we"}, m_we, 0);
      chk({tag, "_mem_addr"}, m_addr, 0);
      chk({tag, "_mem_wdata"}, m_wdata, 0);
      chk({tag, "_core_rst"}, m_cr, 1);
      chk({tag, "_busy"}, m_busy, 0);
      chk({tag, "_done"}, m_done, 0);
      chk({tag, "_err"}, m_err, 0);
      chk({tag, "_word_count"}, m_wc, 0);
   endtask

   // Pulse start for one cycle; afterwards the loader must be in LOAD with cleared status
   task automatic pulse_start();
      set_start(1'b1);
      @(negedge clk);
      set_start(1'b0);
      chk("ready_after_start", m_ready, 1);
      chk("wc_cleared", m_wc, 0);
      chk("err_cleared", m_err, 0);
   endtask

   // gmode: >=0 fixed gap, -1 cycles through pat, -2 random 0..3
   task automatic feed(input int n, input int gmode, input bit use_last, output int acc);
      int g;
      int to;
      acc = 0;
      for (int i = 0; i < n; i++) begin
         if (i == 0)          g = 0;
         else if (gmode == -1) g = pat[(i - 1) % 3];
         else if (gmode == -2) g = int'($urandom_range(0, 3));
         else                  g = gmode;
         set_in(1'b0, '0, 1'b0);
         repeat (g) @(negedge clk);
         set_in(1'b1, words[i], use_last && (i == n - 1));
         to = 0;
         while (!m_ready && !m_done && to < 50) begin
            @(negedge clk);
            to++;
         end
         if (!m_ready) break;
         @(negedge clk);
         acc++;
      end
      set_in(1'b0, '0, 1'b0);
   endtask

   task automatic do_load(input int s, input int n, input int gmode, input bit use_last,
                          input bit poke, input int exp_acc, input int exp_nwr,
                          input int exp_run, input bit exp_err, input int exp_wc,
                          input bit consec);
      int q0, r0, acc, nwr, k;
      logic [31:0] ea, ed;
      sel = s;
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      q0 = wr_q.size();
      r0 = run_cnt;
      pulse_start();
      feed(n, gmode, use_last, acc);
      if (poke) begin
         k = 0;
         while (m_cr && k < 20) begin @(negedge clk); k++; end
         chk("poke_in_run", m_cr, 0);
         set_start(1'b1);
         @(negedge clk);
         set_start(1'b0);
      end
      k = 0;
      while (!m_done && k < 3000) begin @(negedge clk); k++; end
      chk("done_reached", m_done, 1);
      repeat (2) @(negedge clk);
      if (poke) repeat (5) @(negedge clk);
      nwr = wr_q.size() - q0;
      chk("accepted", acc, exp_acc);
      chk("n_writes", nwr, exp_nwr);
      for (int i = 0; i < nwr && i < exp_nwr; i++) begin
         ea = 32'h4 + 32'(4 * i);
         ed = (i < exp_acc) ? words[i] : 32'h0;
         chk("wr_addr", wr_q[q0 + i].addr, ea);
         chk("wr_data", wr_q[q0 + i].data, ed);
      end
      if (consec && nwr > 0)
         chk("wr_consecutive", wr_q[q0 + nwr - 1].cyc - wr_q[q0].cyc, nwr - 1);
      chk("run_cycles", run_cnt - r0, exp_run);
      chk("done_hold", m_done, 1);
      chk("err", m_err, exp_err);
      chk("word_count", m_wc, exp_wc);
      chk("busy_end", m_busy, 0);
      chk("core_rst_end", m_cr, 1);
   endtask

   typedef struct {
      int s;
      int n;
      int gmode;
      bit last;
      int exp_nwr;
      int exp_run;
      bit exp_err;
      int exp_wc;
   } vec_t;

   vec_t vecs[6];

   initial begin
      int s, n, d, acc, run;
      bit last, e;
      pat[0] = 0; pat[1] = 2; pat[2] = 5;
      vecs[0] = '{0, 3, 0,  1'b1, 4, 5, 1'b0, 3};  // A,B,C continuous
      vecs[1] = '{0, 1, 0,  1'b1, 2, 3, 1'b0, 1};  // single word
      vecs[2] = '{0, 4, -1, 1'b1, 5, 6, 1'b0, 4};  // gaps 0,2,5
      vecs[3] = '{1, 5, 0,  1'b0, 4, 0, 1'b1, 4};  // overflow, DEPTH=4
      vecs[4] = '{1, 4, 0,  1'b1, 5, 6, 1'b0, 4};  // s_last on the DEPTH-th word
      vecs[5] = '{1, 2, 1,  1'b1, 3, 4, 1'b0, 2};

      rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
      ifa.s_valid = 1'b0; ifa.s_data = '0; ifa.s_last = 1'b0;
      ifb.s_valid = 1'b0; ifb.s_data = '0; ifb.s_last = 1'b0;
      repeat (3) @(negedge clk);
      sel = 0; #1; chk_reset_vals("rst_a");
      sel = 1; #1; chk_reset_vals("rst_b");
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++)
         do_load(vecs[i].s, vecs[i].n, vecs[i].gmode, vecs[i].last, 1'b0,
                 vecs[i].exp_nwr - (vecs[i].exp_err ? 0 : 1), vecs[i].exp_nwr,
                 vecs[i].exp_run, vecs[i].exp_err, vecs[i].exp_wc, vecs[i].gmode == 0);

      // start pulsed while the core runs is ignored
      do_load(0, 3, 0, 1'b1, 1'b1, 3, 4, 5, 1'b0, 3, 1'b1);

      // Reset mid-load, then reload from the base address
      sel = 0;
      for (int i = 0; i < 16; i++) words[i] = $urandom;
      pulse_start();
      feed(2, 0, 1'b0, acc);
      chk("pre_reset_acc", acc, 2);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_vals("midrst");
      rst = 1'b1;
      @(negedge clk);
      do_load(0, 2, 0, 1'b1, 1'b0, 2, 3, 4, 1'b0, 2, 1'b1);

      // Randomized loads against a length/depth model
      for (int t = 0; t < 10; t++) begin
         s = int'($urandom_range(0, 1));
         d = (s == 0) ? 1024 : 4;
         n = int'($urandom_range(1, (s == 0) ? 10 : 6));
         last = (s == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         if (!last && n < d) last = 1'b1;
         e = !(last && n <= d);
         acc = e ? d : n;
         run = e ? 0 : acc * 1 + 2;
         do_load(s, n, -2, last, 1'b0, acc, acc + (e ? 0 : 1), run, e, acc, 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end
endmodule
